// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running h/v counters with registered sync, video and pulse decodes.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0] frame_cnt,
`endif
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       h_wrap;
    logic       frame_hit;

    // Terminal-count wraps; the vertical counter only moves on the line wrap.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Outputs decode the present counter value, so they trail the counters by one cycle.
    always_comb begin
        frame_hit     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        pixel_x_d     = h_cnt_q;
        pixel_y_d     = v_cnt_q;
        video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_d       = ((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = (h_cnt_q == 10'd0);
        frame_start_d = frame_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       seen_frame_q, seen_frame_d;

    // The first frame after reset reads 0; each later frame start bumps the count.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        seen_frame_d = seen_frame_q;
        if (frame_hit) begin
            if (seen_frame_q) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            seen_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q  <= 8'd0;
            seen_frame_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            seen_frame_q <= seen_frame_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance for line timing and a tiny-raster instance for whole frames.
// The tiny instance uses a 10x8 raster (6 visible, sync at x 7..8, y 5) with active-high sync.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       d_rst, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
    logic [9:0] d_pixel_x, d_pixel_y;
    logic       s_rst, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_pixel_x, s_pixel_y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] d_frame_cnt, s_frame_cnt;
`endif

    vga_sync_gen u_dut_default (
        .clk         (clk),
        .rst         (d_rst),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .video_on    (d_video_on),
        .pixel_x     (d_pixel_x),
        .pixel_y     (d_pixel_y),
        .line_start  (d_line_start),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (d_frame_cnt),
`endif
        .frame_start (d_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .SYNC_POL(1'b1)
    ) u_dut_small (
        .clk         (clk),
        .rst         (s_rst),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .pixel_x     (s_pixel_x),
        .pixel_y     (s_pixel_y),
        .line_start  (s_line_start),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (s_frame_cnt),
`endif
        .frame_start (s_frame_start)
    );

    // {hsync, vsync, video_on, line_start, frame_start, pixel_x, pixel_y}
    function automatic logic [24:0] d_obs();
        return {d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start, d_pixel_x, d_pixel_y};
    endfunction

    function automatic logic [24:0] s_obs();
        return {s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start, s_pixel_x, s_pixel_y};
    endfunction

    task automatic test_reset();
        logic [24:0] exp_v;
        d_rst = 1'b1;
        s_rst = 1'b1;
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (d_obs() !== exp_v) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, d_obs(), exp_v);
            end
        end
        d_rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        checks++;
        if (d_obs() !== exp_v) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", d_obs(), exp_v);
        end
    endtask

    // Starts on the sample showing (0,0) and walks one full line of the default raster.
    task automatic test_h_timing();
        logic [24:0] exp_v;
        int von_cnt = 0;
        int hs_low_cnt = 0;
        int hs_first = -1;
        int n;
        for (int x = 0; x < 800; x++) begin
            exp_v = {!((x >= 656) && (x < 752)), 1'b1, (x < 640), (x == 0), (x == 0), 10'(x), 10'd0};
            checks++;
            if (d_obs() !== exp_v) begin
                failures++;
                $display("FAIL line0_x%0d: got %h expected %h", x, d_obs(), exp_v);
            end
            if (d_video_on === 1'b1) von_cnt++;
            if (d_hsync === 1'b0) begin
                if (hs_first < 0) hs_first = int'(d_pixel_x);
                hs_low_cnt++;
            end
            @(negedge clk);
        end
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd1};
        checks++;
        if (d_obs() !== exp_v) begin
            failures++;
            $display("FAIL line1_start: got %h expected %h", d_obs(), exp_v);
        end
        checks++;
        if (von_cnt != 640) begin
            failures++;
            $display("FAIL video_on_width: got %0d expected 640", von_cnt);
        end
        checks++;
        if (hs_low_cnt != 96 || hs_first != 656) begin
            failures++;
            $display("FAIL hsync_window: got width %0d start %0d expected 96 at 656", hs_low_cnt, hs_first);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (d_line_start !== 1'b1 && n < 1000);
        checks++;
        if (n != 800 || d_pixel_y !== 10'd2) begin
            failures++;
            $display("FAIL line_period: got %0d cycles y=%0d expected 800 cycles y=2", n, d_pixel_y);
        end
    endtask

    task automatic test_mid_line_reset();
        logic [24:0] exp_v;
        int n = 0;
        while (d_pixel_x !== 10'd300 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d_pixel_x !== 10'd300) begin
            failures++;
            $display("FAIL mid_line_wait: got x=%0d expected 300", d_pixel_x);
        end
        d_rst = 1'b1;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        checks++;
        if (d_obs() !== exp_v) begin
            failures++;
            $display("FAIL mid_line_reset: got %h expected %h", d_obs(), exp_v);
        end
        d_rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        checks++;
        if (d_obs() !== exp_v) begin
            failures++;
            $display("FAIL mid_line_restart: got %h expected %h", d_obs(), exp_v);
        end
    endtask

    // Two whole tiny frames plus the first sample of the third, against a hand-written raster model.
    task automatic test_small_frame();
        logic [24:0] exp_v;
        int x = 0;
        int y = 0;
        int vs_cnt = 0;
        int vs_first_x = -1;
        int vs_first_y = -1;
        int fs_cnt = 0;
        logic [9:0] last_x = 10'd0;
        logic [9:0] last_y = 10'd0;
        s_rst = 1'b1;
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= 160; i++) begin
            exp_v = {((x >= 7) && (x < 9)), (y == 5), ((x < 6) && (y < 4)), (x == 0),
                     ((x == 0) && (y == 0)), 10'(x), 10'(y)};
            checks++;
            if (s_obs() !== exp_v) begin
                failures++;
                $display("FAIL small_frame i%0d: got %h expected %h", i, s_obs(), exp_v);
            end
`ifdef VGA_FRAME_CNT_EN
            checks++;
            if (s_frame_cnt !== 8'(i / 80)) begin
                failures++;
                $display("FAIL small_frame_cnt i%0d: got %0d expected %0d", i, s_frame_cnt, i / 80);
            end
`endif
            if (i < 80 && s_vsync === 1'b1) begin
                if (vs_first_x < 0) begin
                    vs_first_x = int'(s_pixel_x);
                    vs_first_y = int'(s_pixel_y);
                end
                vs_cnt++;
            end
            if (s_frame_start === 1'b1) begin
                fs_cnt++;
                if (i > 0) begin
                    checks++;
                    if (last_x !== 10'd9 || last_y !== 10'd7) begin
                        failures++;
                        $display("FAIL small_wrap: got prev (%0d,%0d) expected (9,7)", last_x, last_y);
                    end
                end
            end
            last_x = s_pixel_x;
            last_y = s_pixel_y;
            x++;
            if (x == 10) begin
                x = 0;
                y = (y == 7) ? 0 : y + 1;
            end
            if (i < 160) @(negedge clk);
        end
        checks++;
        if (vs_cnt != 10 || vs_first_x != 0 || vs_first_y != 5) begin
            failures++;
            $display("FAIL small_vsync: got %0d at (%0d,%0d) expected 10 at (0,5)", vs_cnt, vs_first_x, vs_first_y);
        end
        checks++;
        if (fs_cnt != 3) begin
            failures++;
            $display("FAIL small_frame_pulses: got %0d expected 3", fs_cnt);
        end
    endtask

    task automatic test_small_mid_reset();
        logic [24:0] exp_v;
        int n = 0;
        while (!(s_pixel_x === 10'd3 && s_pixel_y === 10'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_pixel_x !== 10'd3 || s_pixel_y !== 10'd2) begin
            failures++;
            $display("FAIL small_mid_wait: got (%0d,%0d) expected (3,2)", s_pixel_x, s_pixel_y);
        end
        s_rst = 1'b1;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        checks++;
        if (s_obs() !== exp_v) begin
            failures++;
            $display("FAIL small_mid_reset: got %h expected %h", s_obs(), exp_v);
        end
        s_rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
        checks++;
        if (s_obs() !== exp_v) begin
            failures++;
            $display("FAIL small_mid_restart: got %h expected %h", s_obs(), exp_v);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    // Entered on the first sample after a reset release, which carries frame_start.
    task automatic test_frame_cnt();
        int n;
        for (int k = 0; k <= 256; k++) begin
            checks++;
            if (s_frame_start !== 1'b1 || s_frame_cnt !== 8'(k)) begin
                failures++;
                $display("FAIL frame_cnt_k%0d: got fs=%b cnt=%0d expected fs=1 cnt=%0d", k, s_frame_start, s_frame_cnt, k % 256);
            end
            if (k < 256) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (s_frame_start !== 1'b1 && n < 200);
            end
        end
        s_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_frame_cnt !== 8'd0) begin
            failures++;
            $display("FAIL frame_cnt_reset: got %0d expected 0", s_frame_cnt);
        end
        s_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_frame_cnt !== 8'd0 || s_frame_start !== 1'b1) begin
            failures++;
            $display("FAIL frame_cnt_first: got cnt=%0d fs=%b expected cnt=0 fs=1", s_frame_cnt, s_frame_start);
        end
    endtask
`endif

    initial begin
        d_rst = 1'b1;
        s_rst = 1'b1;
        test_reset();
        test_h_timing();
        test_mid_line_reset();
        test_small_frame();
        test_small_mid_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
